// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, unit indices, FSM states
// and default datapath widths.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RES_W_DEF  = 67;
  localparam int REM_W_DEF  = 33;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;
  localparam logic [4:0] OP_SHR = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_AND = 5'd7;
  localparam logic [4:0] OP_OR  = 5'd8;
  localparam logic [4:0] OP_XOR = 5'd9;

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_LOG = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an opcode to its one-hot execution unit, adder carry-in and validity.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [4:0] op,
  output logic [3:0] unit,
  output logic       cin,
  output logic       op_valid
);

  always_comb begin
    unit     = '0;
    cin      = 1'b0;
    op_valid = 1'b1;
    case (op)
      OP_ADD: unit[UNIT_ADD] = 1'b1;
      OP_SUB: begin
        unit[UNIT_ADD] = 1'b1;
        cin            = 1'b1;
      end
      OP_MUL: unit[UNIT_MUL] = 1'b1;
      OP_DIV: unit[UNIT_DIV] = 1'b1;
      OP_SHR, OP_SHL, OP_AND, OP_OR, OP_XOR: unit[UNIT_LOG] = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one ALU operation at a time to the selected unit, waits for its
// completion flag (bounded by TIMEOUT) and holds the captured result.
//
// state | meaning
// IDLE  | ready for a request; start latches op and operands
// ISSUE | one cycle, unit enabled, wait counter cleared
// WAIT  | unit enabled, counting until its completion flag or timeout
// DONE  | one-cycle done pulse, unit released
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int REM_W   = REM_W_DEF,
  parameter int TIMEOUT = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [3:0]        suff_in,
  input  logic [RES_W-1:0]  res_in,
  input  logic [REM_W-1:0]  rem_in,
  output logic [DATA_W-1:0] X_q,
  output logic [DATA_W-1:0] Y_q,
  output logic [3:0]        unit_active,
  output logic              cin,
  output logic [4:0]        sel,
  output logic              ready,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic [REM_W-1:0]  remainder,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       dec_op;
  logic [3:0]       dec_unit;
  logic             dec_cin;
  logic             dec_valid;
  logic             hit;
  logic             expired;

  // In IDLE the decoder validates the incoming opcode; afterwards it follows
  // the latched one so the unit enable cannot change mid-operation.
  assign dec_op  = (state == S_IDLE) ? op : sel;
  assign hit     = |(suff_in & dec_unit);
  assign expired = (cnt == CNT_LAST);

  alu_op_decoder u_dec (
    .op       (dec_op),
    .unit     (dec_unit),
    .cin      (dec_cin),
    .op_valid (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = dec_valid ? S_ISSUE : S_DONE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (hit || expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state == S_IDLE);
    done        = (state == S_DONE);
    unit_active = '0;
    cin         = 1'b0;
    if (state == S_ISSUE || state == S_WAIT) begin
      unit_active = dec_unit;
      cin         = dec_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      X_q       <= '0;
      Y_q       <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel       <= op;
            X_q       <= X;
            Y_q       <= Y;
            result    <= '0;
            remainder <= '0;
            err       <= ~dec_valid;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (hit) begin
            result    <= res_in;
            remainder <= (sel == OP_DIV) ? rem_in : '0;
            err       <= 1'b0;
          end else if (expired) begin
            result    <= '0;
            remainder <= '0;
            err       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table with a result
// scoreboard, plus hand-written reset sequences.
module tb_alu_sequencer;

  localparam int DATA_W  = 32;
  localparam int RES_W   = 67;
  localparam int REM_W   = 33;
  localparam int TIMEOUT = 80;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        op;
  logic [DATA_W-1:0] x, y;
  logic [3:0]        suff_in;
  logic [RES_W-1:0]  res_in;
  logic [REM_W-1:0]  rem_in;
  logic [DATA_W-1:0] x_q, y_q;
  logic [3:0]        unit_active;
  logic              cin;
  logic [4:0]        sel;
  logic              ready, done, err;
  logic [RES_W-1:0]  result;
  logic [REM_W-1:0]  remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .DATA_W(DATA_W), .RES_W(RES_W), .REM_W(REM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .X           (x),
    .Y           (y),
    .suff_in     (suff_in),
    .res_in      (res_in),
    .rem_in      (rem_in),
    .X_q         (x_q),
    .Y_q         (y_q),
    .unit_active (unit_active),
    .cin         (cin),
    .sel         (sel),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .err         (err)
  );

  typedef struct {
    logic [4:0]        op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    int                k;        // WAIT cycle index of the completion flag, -1 = never
    logic [3:0]        noise;    // non-selected flag bits held during WAIT
    logic [3:0]        unit;
    logic              cin;
    logic [RES_W-1:0]  res;
    logic [REM_W-1:0]  rem;
    logic [RES_W-1:0]  exp_res;
    logic [REM_W-1:0]  exp_rem;
    logic              exp_err;
    int                exp_lat;  // negedges after the accept edge until done
    bit                extra;    // pulse a second start during WAIT
  } vec_t;

  typedef struct {
    logic [RES_W-1:0] res;
    logic [REM_W-1:0] rem;
    logic             err;
    int               lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ready) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    bit   seen;
    bit   stable;
    v = vecs[idx];
    wait_ready();
    start   = 1'b1;
    op      = v.op;
    x       = v.x;
    y       = v.y;
    res_in  = v.res;
    rem_in  = v.rem;
    suff_in = '0;
    @(posedge clk);
    e.res = v.exp_res;
    e.rem = v.exp_rem;
    e.err = v.exp_err;
    e.lat = v.exp_lat;
    sb.push_back(e);
    seen   = 0;
    stable = 1;
    for (int c = 0; c < TIMEOUT + 20 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      x     = ~v.x;
      y     = ~v.y;
      op    = 5'd5;
      if (v.extra && c == 3) begin
        start = 1'b1;
        op    = 5'd1;
      end
      if (x_q !== v.x || y_q !== v.y || sel !== v.op) stable = 0;
      if (c == 0 && v.exp_lat != 0) begin
        chk($sformatf("v%0d unit_active", idx), 80'(unit_active), 80'(v.unit));
        chk($sformatf("v%0d cin", idx), 80'(cin), 80'(v.cin));
      end
      suff_in = (c >= 1) ? v.noise : 4'b0000;
      if (v.k >= 0 && c == 1 + v.k) suff_in = suff_in | v.unit;
      if (done) begin
        seen = 1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d sb_empty", idx), 80'(sb.size()), 80'(1));
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d latency", idx), 80'(c), 80'(e.lat));
          chk($sformatf("v%0d result", idx), 80'(result), 80'(e.res));
          chk($sformatf("v%0d remainder", idx), 80'(remainder), 80'(e.rem));
          chk($sformatf("v%0d err", idx), 80'(err), 80'(e.err));
          chk($sformatf("v%0d unit_off", idx), 80'(unit_active), 80'(0));
          chk($sformatf("v%0d stable", idx), 80'(stable), 80'(1));
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL v%0d done_timeout: got no done expected done within %0d cycles", idx, TIMEOUT + 20);
    end
    start   = 1'b0;
    suff_in = '0;
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), 80'(done), 80'(0));
    chk($sformatf("v%0d ready_after", idx), 80'(ready), 80'(1));
    @(negedge clk);
    chk($sformatf("v%0d result_hold", idx), 80'(result), 80'(v.exp_res));
    chk($sformatf("v%0d err_hold", idx), 80'(err), 80'(v.exp_err));
  endtask

  initial begin
    int dones;
    //            op     x          y       k    noise    unit     cin   res                     rem     exp_res                 exp_rem exp_err lat extra
    vecs[0] = '{5'd2,  32'd10,    32'd3,  0,   4'b0000, 4'b0001, 1'b1, 67'd7,                  33'd5,  67'd7,                  33'd0,  1'b0, 2,  1'b0};
    vecs[1] = '{5'd4,  32'd100,   32'd7,  35,  4'b1011, 4'b0100, 1'b0, 67'd14,                 33'd2,  67'd14,                 33'd2,  1'b0, 37, 1'b0};
    vecs[2] = '{5'd3,  32'd8,     32'd9,  -1,  4'b0001, 4'b0010, 1'b0, 67'd99,                 33'd1,  67'd0,                  33'd0,  1'b1, 81, 1'b0};
    vecs[3] = '{5'd12, 32'd1,     32'd2,  0,   4'b0000, 4'b0000, 1'b0, 67'd5,                  33'd5,  67'd0,                  33'd0,  1'b1, 0,  1'b0};
    vecs[4] = '{5'd3,  32'd6,     32'd7,  2,   4'b0000, 4'b0010, 1'b0, 67'd42,                 33'd3,  67'd42,                 33'd0,  1'b0, 4,  1'b1};
    vecs[5] = '{5'd1,  32'd5,     32'd6,  0,   4'b1110, 4'b0001, 1'b0, 67'd11,                 33'd1,  67'd11,                 33'd0,  1'b0, 2,  1'b0};
    vecs[6] = '{5'd9,  32'hF0,    32'h0F, 1,   4'b0000, 4'b1000, 1'b0, 67'hFF,                 33'd0,  67'hFF,                 33'd0,  1'b0, 3,  1'b0};
    vecs[7] = '{5'd1,  32'd1,     32'd1,  79,  4'b0000, 4'b0001, 1'b0, 67'd2,                  33'd0,  67'd2,                  33'd0,  1'b0, 81, 1'b0};
    vecs[8] = '{5'd0,  32'd3,     32'd3,  0,   4'b0000, 4'b0000, 1'b0, 67'd9,                  33'd9,  67'd0,                  33'd0,  1'b1, 0,  1'b0};
    vecs[9] = '{5'd6,  32'd1,     32'd4,  0,   4'b0000, 4'b1000, 1'b0, 67'h7_0000_0000_0000_0010, 33'd0, 67'h7_0000_0000_0000_0010, 33'd0, 1'b0, 2, 1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    op      = '0;
    x       = '0;
    y       = '0;
    suff_in = '0;
    res_in  = '0;
    rem_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 80'(ready), 80'(1));
    chk("rst done", 80'(done), 80'(0));
    chk("rst result", 80'(result), 80'(0));
    chk("rst err", 80'(err), 80'(0));
    chk("rst unit_active", 80'(unit_active), 80'(0));
    chk("rst x_q", 80'(x_q), 80'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i);
    chk("sb drained", 80'(sb.size()), 80'(0));

    // reset in the middle of a divide wait
    wait_ready();
    start  = 1'b1;
    op     = 5'd4;
    x      = 32'd100;
    y      = 32'd7;
    res_in = 67'd14;
    rem_in = 33'd2;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midwait unit_active", 80'(unit_active), 80'(4));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ready", 80'(ready), 80'(1));
    chk("midrst unit_active", 80'(unit_active), 80'(0));
    chk("midrst result", 80'(result), 80'(0));
    chk("midrst done", 80'(done), 80'(0));
    chk("midrst sel", 80'(sel), 80'(0));
    chk("midrst x_q", 80'(x_q), 80'(0));
    chk("midrst cin", 80'(cin), 80'(0));
    rst     = 1'b0;
    suff_in = 4'b0100;
    dones   = 0;
    repeat (TIMEOUT + 10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst no_done", 80'(dones), 80'(0));
    chk("midrst idle", 80'(ready), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter RES_W, default 67, result width.
REQ-003 SHALL have parameter REM_W, default 33, remainder width.
REQ-004 SHALL have parameter TIMEOUT, default 80, maximum WAIT cycles before abort.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request strobe; accepted only when ready=1.
REQ-008 SHALL have port op, input, 5, opcode: 1 add, 2 sub, 3 mul, 4 div, 5 shr, 6 shl, 7 and, 8 or, 9 xor.
REQ-009 SHALL have ports X and Y, input, DATA_W each, operands.
REQ-010 SHALL have port suff_in, input, 4: [0] adder, [1] multiplier, [2] divider, [3] logic-unit completion.
REQ-011 SHALL have ports res_in (input, RES_W) and rem_in (input, REM_W): selected-unit result and divider remainder.
REQ-012 SHALL have ports X_q and Y_q, output, DATA_W each: registered operands driven to all units.
REQ-013 SHALL have port unit_active, output, 4, one-hot enable in the same bit order as suff_in.
REQ-014 SHALL have port cin, output, 1: adder carry-in, 1 only for sub.
REQ-015 SHALL have port sel, output, 5: latched opcode to the result mux.
REQ-016 SHALL have ports ready (output, 1, idle) and done (output, 1, one-cycle completion pulse).
REQ-017 SHALL have ports result (output, RES_W), remainder (output, REM_W) and err (output, 1, invalid op or timeout).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; ready=1 only in IDLE.
REQ-019 IDLE: start=1 SHALL latch op, X, Y into sel, X_q, Y_q; valid op -> ISSUE, op 0 or >9 -> DONE with err=1.
REQ-020 ISSUE SHALL last one cycle, assert the op's unit_active bit, clear the wait counter, then go to WAIT.
REQ-021 WAIT SHALL hold unit_active and increment the counter each cycle.
REQ-022 WAIT SHALL sample only the selected unit's suff_in bit and ignore the other bits.
REQ-023 On the selected suff_in bit =1 in WAIT, SHALL capture res_in into result, capture rem_in into remainder (div only, else 0), set err=0 and go to DONE.
REQ-024 If the counter reaches TIMEOUT-1 without suff, SHALL go to DONE with err=1, result=0, remainder=0.
REQ-025 If suff and timeout coincide, completion SHALL win (err=0).
REQ-026 DONE SHALL assert done for exactly one cycle, drop unit_active, then return to IDLE.
REQ-027 result, remainder and err SHALL hold from DONE until the next accepted start.
REQ-028 start while ready=0 SHALL be ignored and not queued.
REQ-029 Minimum latency: start accepted at edge N -> done high at cycle N+3, given suff on the first WAIT cycle.
REQ-030 X_q, Y_q and sel SHALL stay stable from acceptance until DONE exits.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, including mid-operation, aborting it with no done pulse.
REQ-032 rst=1 SHALL zero unit_active, cin, done, err, result, remainder, X_q, Y_q, sel and the counter, with ready=1, all on the same edge.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode constants, FSM state enum, unit-index constants and the DATA_W/RES_W/REM_W defaults.
REQ-034 Combinational sub-module alu_op_decoder SHALL map op to one-hot unit, cin and op_valid; all state stays in alu_sequencer.

Verification
REQ-035 op=2, X=10, Y=3, suff_in[0] high in WAIT, res_in=7 -> cin=1, unit_active=0001, done at N+3, result=7, err=0.
REQ-036 op=4, X=100, Y=7, suff_in[2] after 35 WAIT cycles, res_in=14, rem_in=2 -> result=14, remainder=2, single done pulse.
REQ-037 op=3, suff_in never asserted -> done after TIMEOUT WAIT cycles, err=1, result=0; a suff_in[0] glitch during WAIT is ignored.
REQ-038 op=12 -> no unit_active, done at N+1, err=1; a second start during WAIT of an op=3 request is ignored.
REQ-039 rst=1 mid-WAIT of op=4 -> next cycle ready=1, unit_active=0, result=0, no done pulse.
